// File: rtl/run_seq_pkg.sv
// Shared types for the run sequencer: FSM states and completion status codes.
package run_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_ABORT   = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_BADIDX  = 2'd3
    } run_status_t;

endpackage

// File: rtl/prog_table.sv
// Program entry-address table: synchronous write, combinational read, async clear.
// Out-of-range write indices match no entry and are dropped; out-of-range reads return 0.
module prog_table #(
    parameter int instr_width = 9,
    parameter int num_progs   = 4,
    parameter int prog_w      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [prog_w-1:0]      wr_idx,
    input  logic [instr_width-1:0] wr_addr,
    input  logic [prog_w-1:0]      rd_idx,
    output logic [instr_width-1:0] rd_addr
);

    logic [instr_width-1:0] entry [num_progs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < num_progs; i++) entry[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < num_progs; i++) begin
                if (wr_idx == prog_w'(i)) entry[i] <= wr_addr;
            end
        end
    end

    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < num_progs; i++) begin
            if (rd_idx == prog_w'(i)) rd_addr = entry[i];
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Launches a program run on the PC, counts RUN cycles until halt/abort/timeout,
// and hands back a completion record over a valid/ready handshake.
//
// state  | meaning
// IDLE   | ready for a run request
// LAUNCH | one-cycle start pulse to the program counter
// RUN    | program executing, cycle counter advancing
// DONE   | completion record held until consumed
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int                   instr_width = 9,
    parameter int                   num_progs   = 4,
    parameter int                   prog_w      = 2,
    parameter int                   cyc_width   = 16,
    parameter logic [cyc_width-1:0] max_cycles  = 16'd50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [prog_w-1:0]      cfg_idx,
    input  logic [instr_width-1:0] cfg_addr,
    input  logic                   req_valid,
    input  logic [prog_w-1:0]      req_prog,
    output logic                   req_ready,
    input  logic                   halt,
    input  logic                   abort,
    output logic                   start,
    output logic [instr_width-1:0] start_addr,
    output logic                   busy,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic [1:0]             done_status,
    output logic [cyc_width-1:0]   done_cycles
);

    run_state_t             state, state_nxt;
    run_status_t            status_q, status_nxt;
    logic [cyc_width-1:0]   cnt, cnt_nxt;
    logic [cyc_width-1:0]   cycles_nxt;
    logic [instr_width-1:0] addr_nxt;
    logic [instr_width-1:0] tbl_addr;
    logic                   idx_ok;

    prog_table #(
        .instr_width(instr_width),
        .num_progs  (num_progs),
        .prog_w     (prog_w)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (cfg_we),
        .wr_idx (cfg_idx),
        .wr_addr(cfg_addr),
        .rd_idx (req_prog),
        .rd_addr(tbl_addr)
    );

    assign idx_ok      = int'(req_prog) < num_progs;
    assign done_status = status_q;

    always_comb begin
        state_nxt  = state;
        status_nxt = status_q;
        cnt_nxt    = cnt;
        cycles_nxt = done_cycles;
        addr_nxt   = start_addr;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (idx_ok) begin
                        addr_nxt  = tbl_addr;
                        cnt_nxt   = '0;
                        state_nxt = S_LAUNCH;
                    end else begin
                        addr_nxt   = '0;
                        status_nxt = ST_BADIDX;
                        cycles_nxt = '0;
                        state_nxt  = S_DONE;
                    end
                end
            end
            S_LAUNCH: begin
                // counter holds the index of the current RUN cycle, so the first one reads 1
                cnt_nxt   = cyc_width'(1);
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    status_nxt = ST_OK;
                    cycles_nxt = cnt;
                    state_nxt  = S_DONE;
                end else if (abort) begin
                    status_nxt = ST_ABORT;
                    cycles_nxt = cnt;
                    state_nxt  = S_DONE;
                end else if (cnt >= max_cycles) begin
                    status_nxt = ST_TIMEOUT;
                    cycles_nxt = cnt;
                    state_nxt  = S_DONE;
                end else begin
                    cnt_nxt = cnt + cyc_width'(1);
                end
            end
            S_DONE: begin
                if (done_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            status_q    <= ST_OK;
            cnt         <= '0;
            done_cycles <= '0;
            start_addr  <= '0;
            req_ready   <= 1'b1;
            start       <= 1'b0;
            busy        <= 1'b0;
            done_valid  <= 1'b0;
        end else begin
            state       <= state_nxt;
            status_q    <= status_nxt;
            cnt         <= cnt_nxt;
            done_cycles <= cycles_nxt;
            start_addr  <= addr_nxt;
            req_ready   <= (state_nxt == S_IDLE);
            start       <= (state_nxt == S_LAUNCH);
            busy        <= (state_nxt == S_LAUNCH) || (state_nxt == S_RUN);
            done_valid  <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: directed scenarios plus randomized runs
// scored against a cycle-indexed model of the run outcome and a mirror of the table.
module tb_run_sequencer;

    localparam int          IW   = 9;
    localparam int          NP   = 3;
    localparam int          PW   = 2;
    localparam int          CW   = 16;
    localparam logic [15:0] MAXC = 16'd8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [PW-1:0] cfg_idx = '0;
    logic [IW-1:0] cfg_addr = '0;
    logic          req_valid = 1'b0;
    logic [PW-1:0] req_prog = '0;
    logic          req_ready;
    logic          halt = 1'b0;
    logic          abort = 1'b0;
    logic          start;
    logic [IW-1:0] start_addr;
    logic          busy;
    logic          done_valid;
    logic          done_ready = 1'b0;
    logic [1:0]    done_status;
    logic [CW-1:0] done_cycles;

    always #5 clk = ~clk;

    run_sequencer #(
        .instr_width(IW),
        .num_progs  (NP),
        .prog_w     (PW),
        .cyc_width  (CW),
        .max_cycles (MAXC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_addr   (cfg_addr),
        .req_valid  (req_valid),
        .req_prog   (req_prog),
        .req_ready  (req_ready),
        .halt       (halt),
        .abort      (abort),
        .start      (start),
        .start_addr (start_addr),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_status(done_status),
        .done_cycles(done_cycles)
    );

    int total = 0;
    int bad   = 0;
    logic [IW-1:0] mdl [NP];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one edge; mirror any table write the DUT sees on that edge
    task automatic step();
        @(posedge clk);
        if (cfg_we && int'(cfg_idx) < NP) mdl[cfg_idx] = cfg_addr;
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},   32'(req_ready),   32'd1);
        chk({tag, "_start"}, 32'(start),       32'd0);
        chk({tag, "_addr"},  32'(start_addr),  32'd0);
        chk({tag, "_busy"},  32'(busy),        32'd0);
        chk({tag, "_dv"},    32'(done_valid),  32'd0);
        chk({tag, "_st"},    32'(done_status), 32'd0);
        chk({tag, "_cyc"},   32'(done_cycles), 32'd0);
    endtask

    task automatic cfg_write(input int idx, input logic [IW-1:0] a);
        cfg_we   = 1'b1;
        cfg_idx  = PW'(idx);
        cfg_addr = a;
        step();
    endtask

    // halt_at/abort_at: RUN cycle index at which to assert (0 = never)
    task automatic run_one(input int p, input int halt_at, input int abort_at,
                           input int done_wait, input bit hit_write, input logic [IW-1:0] new_addr);
        logic [IW-1:0] exp_addr;
        int exp_st;
        int exp_cyc;
        int k;
        bit fin;
        exp_st  = 3;
        exp_cyc = 0;
        chk("idle_rdy", 32'(req_ready), 32'd1);
        chk("idle_dv",  32'(done_valid), 32'd0);
        req_valid = 1'b1;
        req_prog  = PW'(p);
        if (p < NP) exp_addr = mdl[p];
        else        exp_addr = '0;
        if (hit_write) begin
            cfg_we   = 1'b1;
            cfg_idx  = PW'(p);
            cfg_addr = new_addr;
        end
        step();
        req_valid = 1'b0;
        if (p >= NP) begin
            chk("bad_start", 32'(start), 32'd0);
            chk("bad_busy",  32'(busy),  32'd0);
        end else begin
            chk("launch_start", 32'(start), 32'd1);
            chk("launch_addr",  32'(start_addr), 32'(exp_addr));
            chk("launch_busy",  32'(busy), 32'd1);
            chk("launch_rdy",   32'(req_ready), 32'd0);
            chk("launch_dv",    32'(done_valid), 32'd0);
            halt  = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
            step();
            halt  = 1'b0;
            abort = 1'b0;
            fin = 1'b0;
            k = 1;
            while (!fin) begin
                chk("run_start", 32'(start), 32'd0);
                chk("run_busy",  32'(busy), 32'd1);
                chk("run_dv",    32'(done_valid), 32'd0);
                halt  = (k == halt_at);
                abort = (k == abort_at);
                if ($urandom_range(0, 2) == 0) begin
                    cfg_we   = 1'b1;
                    cfg_idx  = PW'($urandom_range(0, 3));
                    cfg_addr = IW'($urandom);
                end
                if (halt)                 begin exp_st = 0; fin = 1'b1; end
                else if (abort)           begin exp_st = 1; fin = 1'b1; end
                else if (k == int'(MAXC)) begin exp_st = 2; fin = 1'b1; end
                exp_cyc = k;
                step();
                halt  = 1'b0;
                abort = 1'b0;
                k++;
            end
        end
        chk("done_dv",    32'(done_valid), 32'd1);
        chk("done_st",    32'(done_status), 32'(exp_st));
        chk("done_cyc",   32'(done_cycles), 32'(exp_cyc));
        chk("done_busy",  32'(busy), 32'd0);
        chk("done_start", 32'(start), 32'd0);
        chk("done_rdy",   32'(req_ready), 32'd0);
        chk("done_addr",  32'(start_addr), 32'(exp_addr));
        for (int i = 0; i < done_wait; i++) begin
            halt  = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
            step();
            chk("hold_dv",  32'(done_valid), 32'd1);
            chk("hold_st",  32'(done_status), 32'(exp_st));
            chk("hold_cyc", 32'(done_cycles), 32'(exp_cyc));
            chk("hold_rdy", 32'(req_ready), 32'd0);
        end
        halt       = 1'b0;
        abort      = 1'b0;
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk("ret_dv",   32'(done_valid), 32'd0);
        chk("ret_rdy",  32'(req_ready), 32'd1);
        chk("ret_busy", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_run();
        req_valid = 1'b1;
        req_prog  = PW'(1);
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        for (int i = 0; i < NP; i++) mdl[i] = '0;
        #2;
        rst_n = 1'b1;
        step();
        chk_reset_outputs("mid_post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NP; i++) mdl[i] = '0;
        #12;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step();
        chk_reset_outputs("rst_rel");

        cfg_write(1, 9'h040);
        run_one(1, 5, 0, 0, 1'b0, '0);
        run_one(0, 0, 0, 1, 1'b0, '0);
        run_one(1, 3, 3, 0, 1'b0, '0);
        run_one(0, 0, 2, 0, 1'b0, '0);
        run_one(2, 8, 0, 0, 1'b0, '0);
        run_one(2, 0, 8, 0, 1'b0, '0);
        run_one(3, 0, 0, 2, 1'b0, '0);
        run_one(0, 2, 0, 10, 1'b0, '0);
        run_one(1, 1, 0, 0, 1'b0, '0);
        cfg_write(3, 9'h1ff);
        run_one(2, 0, 4, 0, 1'b1, 9'h1a5);
        run_one(2, 1, 0, 0, 1'b0, '0);

        reset_mid_run();
        run_one(1, 2, 0, 0, 1'b0, '0);

        for (int n = 0; n < 40; n++) begin
            run_one($urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 10),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), IW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Launches, supervises and retires program runs on the emulated core. Holds a small writable table of program entry addresses and accepts a run request over a valid/ready handshake. For each run it pulses the program counter's `start`/`start_addr` inputs, counts execution cycles until the decoder's halt, an abort or a timeout, and returns a completion record over a second valid/ready handshake. Sits between the test harness/top level and `prog_counter`.

## Interface
Parameters:
- `instr_width`, 9, width of instruction addresses (matches the program counter)
- `num_progs`, 4, entries in the entry-address table
- `prog_w`, 2, width of program index; must satisfy 2**prog_w >= num_progs
- `cyc_width`, 16, width of the cycle counter
- `max_cycles`, 16'd50000, run cycle budget before timeout; must be >= 1

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cfg_we` in 1: write the entry-address table
- `cfg_idx` in prog_w: table index for the write
- `cfg_addr` in instr_width: entry address to write
- `req_valid` in 1: run request valid
- `req_prog` in prog_w: program index to run
- `req_ready` out 1: sequencer can accept a request
- `halt` in 1: decoder has executed the halt instruction
- `abort` in 1: harness abort of the current run
- `start` out 1: to `prog_counter.start`
- `start_addr` out instr_width: to `prog_counter.start_addr`
- `busy` out 1: a run is launching or executing
- `done_valid` out 1: completion record valid
- `done_ready` in 1: completion record consumed
- `done_status` out 2: run outcome
- `done_cycles` out cyc_width: RUN cycles consumed

## Operation
- States: IDLE, LAUNCH, RUN, DONE. All outputs are registered.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: capture `start_addr` <= table[`req_prog`] and go to LAUNCH.
  - If `req_prog` >= num_progs: capture address 0 and record status BADIDX. Go to DONE directly with `done_cycles`=0 and no start pulse.
- LAUNCH: exactly one cycle.
  - `start`=1, `busy`=1, counter cleared to 0. Next state RUN.
- RUN: `busy`=1, `start`=0. Counter increments every cycle; the first RUN cycle counts as 1.
  - Exit priority when several are true in the same cycle: `halt` (OK) > `abort` (ABORT) > counter == max_cycles (TIMEOUT). Exit goes to DONE with `done_cycles` = counter value in that cycle.
  - `halt`/`abort` outside RUN are ignored.
- DONE:
  - `done_valid`=1; `done_status` and `done_cycles` are held stable until `done_ready`.
  - On `done_ready`: go to IDLE. `req_ready` rises on the following cycle, so there is no same-cycle re-accept.
- Status codes: OK=0, ABORT=1, TIMEOUT=2, BADIDX=3.
- Table writes:
  - Accepted in any state; take effect on the next edge.
  - If a write and an accept hit the same index in the same cycle, the run uses the old address.
  - A write during RUN never alters the running program's address.
  - Writes with `cfg_idx` >= num_progs are dropped.

## Timing
- Reset values: state IDLE, `req_ready`=1, `start`=0, `start_addr`=0, `busy`=0, `done_valid`=0, `done_status`=0, `done_cycles`=0, counter 0, all table entries 0.
- Accept at edge N -> `start`=1 during cycle N+1 -> the PC holds `start_addr` after edge N+2, which is the first RUN cycle.
- The counter saturates at max_cycles and never wraps.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values. The table is also cleared. No completion record is produced.

## Structure
- Package `run_seq_pkg`: state enum `run_state_t` and status enum `run_status_t` with the codes above.
- Sub-module `prog_table`: num_progs x instr_width register file with synchronous write, combinational read and async-low clear.
- The FSM, counter and output registers live in `run_sequencer`.

## Test plan
- Reset, write table[1]=9'h040, request prog 1 -> `start` high for exactly one cycle with `start_addr`=9'h040. Assert `halt` on the 5th RUN cycle -> `done_status`=OK, `done_cycles`=5.
- With `max_cycles`=8, run with no halt -> TIMEOUT and `done_cycles`=8 on the 8th RUN cycle. `halt` and `abort` in the same cycle -> OK.
- Request prog 3 with `num_progs`=3 -> no start pulse, BADIDX, `done_cycles`=0.
- Hold `done_ready`=0 for 10 cycles -> record stable and `req_ready`=0 throughout. Pulse `done_ready` -> IDLE next cycle, and a back-to-back second request is accepted.
- Write table[2] in the accept cycle of prog 2 -> old address used; a later run uses the new one.
- Drop `rst_n` on the 3rd RUN cycle -> all outputs at reset values asynchronously, no `done_valid`.
